// File: rtl/sdram_ex_pkg.sv
// Shared definitions for the SDRAM pattern-test read-back checker.
//   LFSR_POLY  : feedback taps of x^8+x^4+x^3+x^2+1 (low byte of the polynomial)
//   lfsr8_step : one shift of the byte-wide Galois LFSR
//   state_t    : checker FSM states
package sdram_ex_pkg;

  localparam logic [7:0] LFSR_POLY = 8'h1D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Shift left; fold the polynomial back in when the msb falls off.
  function automatic logic [7:0] lfsr8_step(input logic [7:0] d);
    return {d[6:0], 1'b0} ^ (d[7] ? LFSR_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/sdram_ex_lfsr8.sv
// One byte lane of expected read data.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset (q returns to SEED)
//   enable       : low -> q reloads SEED (used in idle and on the start cycle)
//   pause        : high -> q holds (no read word consumed this cycle)
//   load         : with enable && !pause, q takes ldata instead of stepping
//   ldata        : value loaded when resynchronising to the incoming stream
//   q            : current expected byte
module sdram_ex_lfsr8
  import sdram_ex_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       pause,
  input  logic       load,
  input  logic [7:0] ldata,
  output logic [7:0] q
);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= SEED;
    end else if (!enable) begin
      q <= SEED;
    end else if (!pause) begin
      q <= load ? ldata : lfsr8_step(q);
    end
  end

endmodule

// File: rtl/sdram_ex_lfsr_checker.sv
// Read-back checker for the SDRAM pattern test. Regenerates the per-lane LFSR
// stream, compares every valid read word, counts mismatching words and keeps
// the first failure.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   start         : pulse, begins a run (accepted only in IDLE or DONE)
//   abort         : synchronous return to IDLE with results cleared (beats start)
//   rdata_valid   : rdata carries a read word this cycle
//   rdata         : read word, byte lane i in bits [8i+7:8i]
//   busy          : run in progress
//   done, pass    : run finished / finished with no mismatches (levels)
//   err_cnt       : mismatching words, saturating
//   word_cnt      : words consumed in this run
//   first_idx/exp/got : index, expected and received word of the first mismatch
module sdram_ex_lfsr_checker
  import sdram_ex_pkg::*;
#(
  parameter int SEED       = 32,
  parameter int LANES      = 4,
  parameter int LEN        = 1024,
  parameter int CNT_W      = 16,
  parameter int SYNC_FIRST = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 rdata_valid,
  input  logic [8*LANES-1:0]   rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     word_cnt,
  output logic [CNT_W-1:0]     first_idx,
  output logic [8*LANES-1:0]   first_exp,
  output logic [8*LANES-1:0]   first_got
);

  localparam int               DATA_W   = 8 * LANES;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

  state_t            state;
  logic              running;
  logic              start_take;
  logic              lane_en;
  logic              lane_pause;
  logic              lane_load;
  logic              mismatch;
  logic              last_word;
  logic [DATA_W-1:0] exp_word;

  assign running    = (state == ST_SEED) || (state == ST_CHECK);
  assign start_take = start && !abort && !running;

  // Lanes reload their seeds while idle and on the accepted start cycle, and
  // only move when a word is actually consumed.
  assign lane_en    = !start_take && (state != ST_IDLE);
  assign lane_pause = !(rdata_valid && running);
  assign lane_load  = rdata_valid && (state == ST_SEED);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [7:0] LANE_SEED = 8'((SEED + i) % 256);

    sdram_ex_lfsr8 #(
      .SEED(LANE_SEED)
    ) u_lfsr (
      .clk    (clk),
      .reset_n(reset_n),
      .enable (lane_en),
      .pause  (lane_pause),
      .load   (lane_load),
      .ldata  (lfsr8_step(rdata[8*i +: 8])),
      .q      (exp_word[8*i +: 8])
    );
  end

  assign mismatch  = (rdata != exp_word);
  // word_cnt is the index of the word being consumed, so the run ends on LEN-1.
  assign last_word = (word_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      word_cnt  <= '0;
      first_idx <= '0;
      first_exp <= '0;
      first_got <= '0;
    end else if (abort) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      word_cnt  <= '0;
      first_idx <= '0;
      first_exp <= '0;
      first_got <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= (SYNC_FIRST != 0) ? ST_SEED : ST_CHECK;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            word_cnt  <= '0;
            first_idx <= '0;
            first_exp <= '0;
            first_got <= '0;
          end
        end

        ST_SEED: begin
          if (rdata_valid) begin
            word_cnt <= CNT_ONE;
            // A one-word run has nothing left to compare after resync.
            if (last_word) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          if (rdata_valid) begin
            word_cnt <= word_cnt + CNT_ONE;
            if (mismatch) begin
              if (err_cnt == '0) begin
                first_idx <= word_cnt;
                first_exp <= exp_word;
                first_got <= rdata;
              end
              if (err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + CNT_ONE;
              end
            end
            if (last_word) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_cnt == '0) && !mismatch;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_ex_lfsr_checker.sv
// Self-checking bench for sdram_ex_lfsr_checker. Four checker instances with
// different parameter sets share clk/reset_n; a bench-side LFSR model predicts
// counters, first-failure capture and flags, pushed to a scoreboard queue as
// each cycle of stimulus is driven and popped after the DUT's clock edge.
module tb_sdram_ex_lfsr_checker;

  localparam int NI   = 4;
  localparam int SEED = 32;

  // Instance 0: LANES=1 LEN=4; 1: LANES=4 LEN=6; 2: SYNC_FIRST LEN=3; 3: CNT_W=4 LEN=15
  function automatic int lanes_of(input int g);
    return (g == 1) ? 4 : 1;
  endfunction
  function automatic int len_of(input int g);
    case (g)
      0: return 4;
      1: return 6;
      2: return 3;
      default: return 15;
    endcase
  endfunction
  function automatic int sync_of(input int g);
    return (g == 2) ? 1 : 0;
  endfunction
  function automatic int cntw_of(input int g);
    return (g == 3) ? 4 : 16;
  endfunction

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] start;
  logic [NI-1:0] abort;
  logic [NI-1:0] valid;
  logic [31:0]   rdata [NI];

  logic        o_busy [NI];
  logic        o_done [NI];
  logic        o_pass [NI];
  logic [31:0] o_err  [NI];
  logic [31:0] o_wc   [NI];
  logic [31:0] o_fidx [NI];
  logic [31:0] o_fexp [NI];
  logic [31:0] o_fgot [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LN = lanes_of(g);
    localparam int CW = cntw_of(g);
    logic          busy, done, pass;
    logic [CW-1:0] err, wc, fidx;
    logic [8*LN-1:0] fexp, fgot;

    sdram_ex_lfsr_checker #(
      .SEED(SEED), .LANES(LN), .LEN(len_of(g)), .CNT_W(CW), .SYNC_FIRST(sync_of(g))
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start[g]),
      .abort      (abort[g]),
      .rdata_valid(valid[g]),
      .rdata      (rdata[g][8*LN-1:0]),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_cnt    (err),
      .word_cnt   (wc),
      .first_idx  (fidx),
      .first_exp  (fexp),
      .first_got  (fgot)
    );

    assign o_busy[g] = busy;
    assign o_done[g] = done;
    assign o_pass[g] = pass;
    assign o_err[g]  = 32'(err);
    assign o_wc[g]   = 32'(wc);
    assign o_fidx[g] = 32'(fidx);
    assign o_fexp[g] = 32'(fexp);
    assign o_fgot[g] = 32'(fgot);
  end

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  logic [7:0]  m_lane [NI][4];
  int          m_wc   [NI];
  int          m_ec   [NI];
  int          m_fidx [NI];
  logic [31:0] m_fexp [NI];
  logic [31:0] m_fgot [NI];
  bit          m_run  [NI];
  bit          m_done [NI];
  bit          m_pass [NI];

  typedef struct {
    int          sel;
    int          wc;
    int          ec;
    int          fidx;
    logic [31:0] fexp;
    logic [31:0] fgot;
    bit          busy;
    bit          done;
    bit          pass;
  } exp_t;

  exp_t sb [$];

  function automatic logic [7:0] tb_step(input logic [7:0] d);
    logic [8:0] t;
    t = {d, 1'b0};
    return t[8] ? (t[7:0] ^ 8'h1D) : t[7:0];
  endfunction

  function automatic logic [31:0] model_word(input int sel);
    logic [31:0] w;
    w = '0;
    for (int l = 0; l < lanes_of(sel); l++) w[8*l +: 8] = m_lane[sel][l];
    return w;
  endfunction

  task automatic model_clear(input int sel);
    for (int l = 0; l < 4; l++) m_lane[sel][l] = 8'((SEED + l) % 256);
    m_wc[sel]   = 0;
    m_ec[sel]   = 0;
    m_fidx[sel] = 0;
    m_fexp[sel] = '0;
    m_fgot[sel] = '0;
    m_run[sel]  = 0;
    m_done[sel] = 0;
    m_pass[sel] = 0;
  endtask

  task automatic push_exp(input int sel);
    exp_t e;
    e.sel  = sel;
    e.wc   = m_wc[sel];
    e.ec   = m_ec[sel];
    e.fidx = m_fidx[sel];
    e.fexp = m_fexp[sel];
    e.fgot = m_fgot[sel];
    e.busy = m_run[sel];
    e.done = m_done[sel];
    e.pass = m_pass[sel];
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic sb_compare();
    exp_t e;
    int   s;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_underflow: queue empty, want one entry");
      return;
    end
    e = sb.pop_front();
    s = e.sel;
    n_tests++;
    if (o_wc[s] !== 32'(e.wc) || o_err[s] !== 32'(e.ec)) begin
      n_fail++;
      $display("FAIL counters inst%0d t=%0t: got wc=%0d err=%0d, want wc=%0d err=%0d",
               s, $time, o_wc[s], o_err[s], e.wc, e.ec);
    end
    n_tests++;
    if (o_fidx[s] !== 32'(e.fidx) || o_fexp[s] !== e.fexp || o_fgot[s] !== e.fgot) begin
      n_fail++;
      $display("FAIL first_capture inst%0d t=%0t: got idx=%0d exp=%h got=%h, want idx=%0d exp=%h got=%h",
               s, $time, o_fidx[s], o_fexp[s], o_fgot[s], e.fidx, e.fexp, e.fgot);
    end
    n_tests++;
    if ({o_busy[s], o_done[s], o_pass[s]} !== {e.busy, e.done, e.pass}) begin
      n_fail++;
      $display("FAIL flags inst%0d t=%0t: got busy/done/pass=%b%b%b, want %b%b%b",
               s, $time, o_busy[s], o_done[s], o_pass[s], e.busy, e.done, e.pass);
    end
  endtask

  // ---------------- stimulus primitives (called at a negedge) ----------------
  task automatic feed(input int sel, input logic [31:0] data);
    logic [31:0] exp;
    valid[sel] = 1'b1;
    rdata[sel] = data;
    if (m_run[sel]) begin
      if (sync_of(sel) != 0 && m_wc[sel] == 0) begin
        for (int l = 0; l < lanes_of(sel); l++) m_lane[sel][l] = tb_step(data[8*l +: 8]);
        m_wc[sel] = 1;
      end else begin
        exp = model_word(sel);
        if (data !== exp) begin
          if (m_ec[sel] == 0) begin
            m_fidx[sel] = m_wc[sel];
            m_fexp[sel] = exp;
            m_fgot[sel] = data;
          end
          if (m_ec[sel] != (1 << cntw_of(sel)) - 1) m_ec[sel]++;
        end
        for (int l = 0; l < lanes_of(sel); l++) m_lane[sel][l] = tb_step(m_lane[sel][l]);
        m_wc[sel]++;
      end
      if (m_wc[sel] == len_of(sel)) begin
        m_run[sel]  = 0;
        m_done[sel] = 1;
        m_pass[sel] = (m_ec[sel] == 0);
      end
    end
    push_exp(sel);
    @(negedge clk);
    valid[sel] = 1'b0;
    sb_compare();
  endtask

  task automatic idle(input int sel, input int n);
    valid[sel] = 1'b0;
    repeat (n) begin
      push_exp(sel);
      @(negedge clk);
      sb_compare();
    end
  endtask

  // Start pulse with a junk valid word that must be ignored.
  task automatic start_run(input int sel);
    start[sel] = 1'b1;
    valid[sel] = 1'b1;
    rdata[sel] = 32'hFFFF_FFFF;
    if (!m_run[sel]) begin
      model_clear(sel);
      m_run[sel] = 1;
    end
    push_exp(sel);
    @(negedge clk);
    start[sel] = 1'b0;
    valid[sel] = 1'b0;
    sb_compare();
  endtask

  task automatic abort_pulse(input int sel, input bit with_start);
    abort[sel] = 1'b1;
    start[sel] = with_start;
    model_clear(sel);
    push_exp(sel);
    @(negedge clk);
    abort[sel] = 1'b0;
    start[sel] = 1'b0;
    sb_compare();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int s = 0; s < NI; s++) begin
      n_tests++;
      if ({o_busy[s], o_done[s], o_pass[s]} !== 3'b000 || o_err[s] !== 0 || o_wc[s] !== 0 ||
          o_fidx[s] !== 0 || o_fexp[s] !== 0 || o_fgot[s] !== 0) begin
        n_fail++;
        $display("FAIL reset inst%0d: got busy/done/pass=%b%b%b err=%0d wc=%0d fidx=%0d, want all zero",
                 s, o_busy[s], o_done[s], o_pass[s], o_err[s], o_wc[s], o_fidx[s]);
      end
    end
  endtask

  task automatic test_pass_run();
    start_run(0);
    feed(0, 32'h20);
    feed(0, 32'h40);
    feed(0, 32'h80);
    feed(0, 32'h1D);
    n_tests++;
    if (o_pass[0] !== 1'b1 || o_done[0] !== 1'b1 || o_err[0] !== 0 || o_wc[0] !== 4) begin
      n_fail++;
      $display("FAIL pass_run: got done=%b pass=%b err=%0d wc=%0d, want 1 1 0 4",
               o_done[0], o_pass[0], o_err[0], o_wc[0]);
    end
    // Valid words in DONE change nothing.
    feed(0, 32'h33);
    idle(0, 1);
  endtask

  task automatic test_mismatch();
    start_run(0);
    feed(0, 32'h20);
    feed(0, 32'h40);
    feed(0, 32'h81);
    feed(0, 32'h1D);
    n_tests++;
    if (o_err[0] !== 1 || o_fidx[0] !== 2 || o_fexp[0] !== 32'h80 || o_fgot[0] !== 32'h81 ||
        o_pass[0] !== 1'b0 || o_done[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mismatch: got err=%0d idx=%0d exp=%h got=%h pass=%b done=%b, want 1 2 80 81 0 1",
               o_err[0], o_fidx[0], o_fexp[0], o_fgot[0], o_pass[0], o_done[0]);
    end
  endtask

  task automatic test_gapped_lanes();
    start_run(1);
    n_tests++;
    if (model_word(1) !== 32'h2322_2120) begin
      n_fail++;
      $display("FAIL lane_seeds: got model word %h, want 23222120", model_word(1));
    end
    for (int k = 0; k < len_of(1); k++) begin
      feed(1, model_word(1));
      idle(1, 2);
    end
    n_tests++;
    if (o_pass[1] !== 1'b1 || o_wc[1] !== 6 || o_err[1] !== 0) begin
      n_fail++;
      $display("FAIL gapped: got pass=%b wc=%0d err=%0d, want 1 6 0", o_pass[1], o_wc[1], o_err[1]);
    end
  endtask

  task automatic test_sync_first();
    start_run(2);
    feed(2, 32'h55);
    feed(2, 32'hAA);
    feed(2, 32'h49);
    n_tests++;
    if (o_pass[2] !== 1'b1 || o_wc[2] !== 3 || o_err[2] !== 0) begin
      n_fail++;
      $display("FAIL sync_first: got pass=%b wc=%0d err=%0d, want 1 3 0", o_pass[2], o_wc[2], o_err[2]);
    end
  endtask

  task automatic test_saturate();
    start_run(3);
    for (int k = 0; k < len_of(3); k++) feed(3, model_word(3) ^ 32'h01);
    n_tests++;
    if (o_err[3] !== 15 || o_fidx[3] !== 0 || o_pass[3] !== 1'b0 || o_done[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate: got err=%0d idx=%0d pass=%b done=%b, want 15 0 0 1",
               o_err[3], o_fidx[3], o_pass[3], o_done[3]);
    end
  endtask

  task automatic test_abort_reset();
    // Mid-run abort, then valid words in IDLE are ignored.
    start_run(0);
    feed(0, 32'h20);
    feed(0, 32'h40);
    abort_pulse(0, 1'b0);
    feed(0, 32'h20);
    // Reset pulse while word 2 is on the bus.
    start_run(0);
    feed(0, 32'h20);
    feed(0, 32'h40);
    valid[0] = 1'b1;
    rdata[0] = 32'h80;
    reset_n  = 1'b0;
    #1;
    n_tests++;
    if (o_busy[0] !== 1'b0 || o_wc[0] !== 0 || o_done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b wc=%0d done=%b, want 0 0 0", o_busy[0], o_wc[0], o_done[0]);
    end
    @(negedge clk);
    reset_n  = 1'b1;
    valid[0] = 1'b0;
    for (int s = 0; s < NI; s++) model_clear(s);
    idle(0, 1);
    // start and abort together: abort wins.
    abort_pulse(0, 1'b1);
    idle(0, 1);
    // A clean run from the seed still passes.
    start_run(0);
    feed(0, 32'h20);
    feed(0, 32'h40);
    feed(0, 32'h80);
    feed(0, 32'h1D);
    n_tests++;
    if (o_pass[0] !== 1'b1 || o_wc[0] !== 4) begin
      n_fail++;
      $display("FAIL restart: got pass=%b wc=%0d, want 1 4", o_pass[0], o_wc[0]);
    end
  endtask

  initial begin
    start = '0;
    abort = '0;
    valid = '0;
    for (int s = 0; s < NI; s++) begin
      rdata[s] = '0;
      model_clear(s);
    end
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_pass_run();
    test_mismatch();
    test_gapped_lanes();
    test_sync_first();
    test_saturate();
    test_abort_reset();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
